// File: rtl/fetch_pc_sequencer_if.sv
// fetch_pc_sequencer_if: redirect, imem request/response and decode handshake bundle
// master: the fetch sequencer (drives requests, decode outputs, fault)
// slave: the environment (memory, decode, branch resolution)
interface fetch_pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic            pc_input_sel;
  logic [XLEN-1:0] alu_target;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            fetch_fault;
  modport master (
    input  redirect_valid, pc_input_sel, alu_target,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_fault
  );
  modport slave (
    output redirect_valid, pc_input_sel, alu_target,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_fault
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: owns the fetch PC, issues single-outstanding imem fetches, hands instructions to decode
// clk, reset_n (async active-low)
// bus.redirect_valid/pc_input_sel/alu_target: resolved next-PC selection
// bus.imem_req_*/imem_rsp_*: instruction memory request and one-cycle response
// bus.if_*: held instruction to decode; bus.fetch_fault: sticky misaligned-redirect fault
module fetch_pc_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  reset_n,
  fetch_pc_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_DRAIN, S_HOLD, S_FAULT} state_t;
  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n, if_pc, if_instr;
  logic            take, bad, cap;
  assign take = bus.redirect_valid & bus.pc_input_sel & (bus.alu_target[1:0] == 2'b00);
  assign bad  = bus.redirect_valid & bus.pc_input_sel & (bus.alu_target[1:0] != 2'b00);
  // reset_n gates the request so the port is quiet while reset is held
  assign bus.imem_req_valid = reset_n & (state == S_REQ) & ~take & ~bad;
  assign bus.imem_req_addr  = pc;
  assign bus.if_valid       = (state == S_HOLD);
  assign bus.if_pc          = if_pc;
  assign bus.if_instr       = if_instr;
  assign bus.fetch_fault    = (state == S_FAULT);
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cap     = 1'b0;
    case (state)
      S_REQ: begin
        pc_n    = take ? bus.alu_target : pc;
        state_n = (!take && bus.imem_req_ready) ? S_WAIT : S_REQ;
      end
      S_WAIT: begin
        pc_n    = take ? bus.alu_target : pc;
        cap     = !take && bus.imem_rsp_valid;
        state_n = take ? (bus.imem_rsp_valid ? S_REQ : S_DRAIN)
                       : (bus.imem_rsp_valid ? S_HOLD : S_WAIT);
      end
      S_DRAIN: begin
        pc_n    = take ? bus.alu_target : pc;
        state_n = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
      end
      S_HOLD: begin
        pc_n    = take ? bus.alu_target : (bus.if_ready ? pc + XLEN'(4) : pc);
        state_n = (take || bus.if_ready) ? S_REQ : S_HOLD;
      end
      default: state_n = S_FAULT;
    endcase
    if (bad) begin
      state_n = S_FAULT;
      pc_n    = pc;
      cap     = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      if_pc    <= RESET_PC;
      if_instr <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (cap) begin
        if_pc    <= pc;
        if_instr <= bus.imem_rsp_data;
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb_fetch_pc_sequencer: directed checks of fetch sequencing, redirects, drain, fault and PC wrap
module tb_fetch_pc_sequencer;
  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  fetch_pc_sequencer_if #(.XLEN(32)) bus ();
  fetch_pc_sequencer #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic redirect(input logic v, input logic s, input logic [31:0] t);
    bus.redirect_valid = v;
    bus.pc_input_sel   = s;
    bus.alu_target     = t;
  endtask
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd1);
    chk({tag, "_req_addr"}, bus.imem_req_addr, a);
    tick;
    chk({tag, "_wait_quiet"}, 32'(bus.imem_req_valid), 32'd0);
    tick;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = d;
    #1;
    chk({tag, "_no_comb"}, 32'(bus.if_valid), 32'd0);
    tick;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    chk({tag, "_if_valid"}, 32'(bus.if_valid), 32'd1);
    chk({tag, "_if_pc"}, bus.if_pc, a);
    chk({tag, "_if_instr"}, bus.if_instr, d);
  endtask
  task automatic consume;
    bus.if_ready = 1'b1;
    tick;
    bus.if_ready = 1'b0;
    #1;
  endtask
  initial begin
    reset_n            = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.pc_input_sel   = 1'b0;
    bus.alu_target     = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.if_ready       = 1'b0;
    #12;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    // in-order fetch
    fetch("t1_a", 32'h0, 32'h13);
    consume;
    fetch("t1_b", 32'h4, 32'h13);
    consume;
    chk("t1_next_addr", bus.imem_req_addr, 32'h8);
    chk("t1_req_after_rdy", 32'(bus.imem_req_valid), 32'd1);
    fetch("t1_c", 32'h8, 32'h13);
    consume;
    fetch("t1_d", 32'hC, 32'h13);
    consume;
    // redirect in HOLD overrides if_ready
    fetch("t2_hold", 32'h10, 32'h0000_0093);
    redirect(1'b1, 1'b1, 32'h100);
    bus.if_ready = 1'b1;
    tick;
    redirect(1'b0, 1'b0, 32'h0);
    bus.if_ready = 1'b0;
    #1;
    chk("t2_dropped", 32'(bus.if_valid), 32'd0);
    chk("t2_target", bus.imem_req_addr, 32'h100);
    fetch("t2_deliver", 32'h100, 32'h0000_0113);
    consume;
    chk("t2_seq", bus.imem_req_addr, 32'h104);
    // redirect in REQ withdraws request, then redirect in WAIT drains
    redirect(1'b1, 1'b1, 32'h20);
    #1;
    chk("t3_withdraw", 32'(bus.imem_req_valid), 32'd0);
    tick;
    redirect(1'b0, 1'b0, 32'h0);
    #1;
    chk("t3_req20", bus.imem_req_addr, 32'h20);
    tick;
    redirect(1'b1, 1'b1, 32'h200);
    tick;
    redirect(1'b0, 1'b0, 32'h0);
    #1;
    chk("t3_drain_quiet", 32'(bus.imem_req_valid), 32'd0);
    tick;
    chk("t3_drain_hold", 32'(bus.imem_req_valid), 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_0BAD;
    tick;
    bus.imem_rsp_valid = 1'b0;
    #1;
    chk("t3_discard", 32'(bus.if_valid), 32'd0);
    chk("t3_req200_v", 32'(bus.imem_req_valid), 32'd1);
    chk("t3_req200", bus.imem_req_addr, 32'h200);
    // redirect coincident with response in WAIT: straight back to REQ
    tick;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD1_1BAD;
    redirect(1'b1, 1'b1, 32'h300);
    tick;
    bus.imem_rsp_valid = 1'b0;
    redirect(1'b0, 1'b0, 32'h0);
    #1;
    chk("t4_discard", 32'(bus.if_valid), 32'd0);
    fetch("t4_nodrain", 32'h300, 32'h0000_0213);
    // sel=0 redirects have no effect
    redirect(1'b1, 1'b0, 32'h500);
    tick;
    chk("t5_hold_stays", 32'(bus.if_valid), 32'd1);
    chk("t5_hold_pc", bus.if_pc, 32'h300);
    consume;
    fetch("t5_sel0", 32'h304, 32'h0000_0313);
    redirect(1'b0, 1'b0, 32'h0);
    // misaligned redirect faults
    redirect(1'b1, 1'b1, 32'h102);
    tick;
    redirect(1'b0, 1'b0, 32'h0);
    #1;
    chk("t5_fault", 32'(bus.fetch_fault), 32'd1);
    chk("t5_fault_ifv", 32'(bus.if_valid), 32'd0);
    chk("t5_fault_req", 32'(bus.imem_req_valid), 32'd0);
    bus.imem_rsp_valid = 1'b1;
    tick;
    bus.imem_rsp_valid = 1'b0;
    tick;
    chk("t5_fault_sticky", 32'(bus.fetch_fault), 32'd1);
    chk("t5_fault_noreq", 32'(bus.imem_req_valid), 32'd0);
    chk("t5_fault_late", 32'(bus.if_valid), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_clear", 32'(bus.fetch_fault), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    fetch("t5_refetch", 32'h0, 32'h0000_0413);
    consume;
    // PC wrap
    redirect(1'b1, 1'b1, 32'hFFFF_FFFC);
    tick;
    redirect(1'b0, 1'b0, 32'h0);
    #1;
    fetch("t6_top", 32'hFFFF_FFFC, 32'h0000_0513);
    consume;
    chk("t6_wrap", bus.imem_req_addr, 32'h0);
    // async reset mid-WAIT
    tick;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(bus.imem_req_valid), 32'd0);
    chk("t6_rst_ifv", 32'(bus.if_valid), 32'd0);
    chk("t6_rst_addr", bus.imem_req_addr, 32'h0);
    chk("t6_rst_pc", bus.if_pc, 32'h0);
    @(negedge clk);
    reset_n            = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD2_2BAD;
    tick;
    bus.imem_rsp_valid = 1'b0;
    tick;
    chk("t6_late_ignored", 32'(bus.if_valid), 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0613;
    tick;
    bus.imem_rsp_valid = 1'b0;
    #1;
    chk("t6_refetch_v", 32'(bus.if_valid), 32'd1);
    chk("t6_refetch_pc", bus.if_pc, 32'h0);
    chk("t6_refetch_instr", bus.if_instr, 32'h0000_0613);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
- Owns the architectural fetch PC and sequences instruction fetch through a single-outstanding valid/ready request/response port to instruction memory.
- Hands fetched instructions to decode on a valid/ready handshake.
- Consumes the resolved next-PC selection (pc_input_sel plus ALU target) to apply taken branches and jumps, and squashes wrong-path fetches.
- Sits between instruction memory and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and fetched first
XLEN, 32, PC and instruction width

Ports:
clk  in  1  core clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
redirect_valid  in  1  resolved control-transfer decision present this cycle
pc_input_sel  in  1  0 = PC_INPUT_PC_PLUS_4 (no redirect), 1 = PC_INPUT_ALU (redirect to alu_target)
alu_target  in  XLEN  redirect target address
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address, always equal to pc
imem_rsp_valid  in  1  response data valid, one cycle pulse
imem_rsp_data  in  XLEN  fetched instruction word
if_valid  out  1  instruction available to decode
if_ready  in  1  decode consumes instruction
if_pc  out  XLEN  PC of held instruction
if_instr  out  XLEN  held instruction word
fetch_fault  out  1  sticky misaligned-redirect fault

Behaviour:
- Reset (async assert, any state): pc=RESET_PC, state=REQ, if_valid=0, if_instr=0, if_pc=RESET_PC, fetch_fault=0, imem_req_valid=0 while reset_n=0.
- take = redirect_valid & pc_input_sel & (alu_target[1:0]==0).
- bad = redirect_valid & pc_input_sel & (alu_target[1:0]!=0).
- redirect_valid with pc_input_sel=0 has no effect in any state.
- Priority in every state: bad > take > normal flow.
- States:
  - REQ: imem_req_valid = !take & !bad. Memory port permits withdrawal of an unaccepted request.
    - take: pc<=alu_target; stay REQ.
    - Else imem_req_ready: go WAIT.
  - WAIT: imem_req_valid=0. Exactly one request is outstanding. Response arrives ≥1 cycle after acceptance.
    - take & !imem_rsp_valid: pc<=alu_target; go DRAIN.
    - take & imem_rsp_valid: discard response; pc<=alu_target; go REQ.
    - imem_rsp_valid only: if_instr<=imem_rsp_data, if_pc<=pc, if_valid<=1; go HOLD.
  - DRAIN: imem_req_valid=0. Wait for the squashed response and discard it.
    - On imem_rsp_valid: go REQ.
    - Further take in DRAIN: update pc only.
  - HOLD: if_valid=1, registered.
    - take: held instruction dropped (handshake not counted even if if_ready=1); if_valid<=0; pc<=alu_target; go REQ.
    - Else if_ready: if_valid<=0; pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); go REQ.
  - FAULT: entered on bad from any state. fetch_fault=1, if_valid=0, imem_req_valid=0.
    - Any late response is ignored.
    - Exit only via reset.
- Latency:
  - Request accept to if_valid: 1 cycle after rsp_valid.
  - if_ready handshake to next imem_req_valid: 1 cycle.
  - Redirect in HOLD or REQ to request at target: next cycle.
- No combinational path from imem_rsp_* to if_*.
- Combinational paths exist from redirect/pc_input_sel/alu_target to imem_req_valid only.

Test Plan:
1. Reset release, imem_req_ready=1, response 2 cycles after accept with data 32'h0000_0013, if_ready=1 → requests at 0x0, 0x4, 0x8 in order; if_pc/if_instr = 0x0/0x13 then 0x4.
2. Redirect in HOLD: held instr at 0x10, redirect_valid=1, sel=1, alu_target=0x100, same cycle as if_ready=1 → instr not consumed, next imem_req_addr=0x100, if_pc=0x100 on following delivery.
3. Redirect in WAIT (req 0x20 accepted) to 0x200 → DRAIN; late response for 0x20 discarded (if_valid stays 0); next request 0x200.
4. Redirect coincident with imem_rsp_valid in WAIT → response discarded, REQ at target next cycle, no DRAIN.
5. redirect_valid=1, sel=0 in each state → no change in pc or state; sel=1, alu_target=0x102 → fetch_fault=1, no further requests; reset_n pulse low clears fault and refetches RESET_PC.
6. pc=32'hFFFF_FFFC consumed → next request 0x0; reset_n asserted mid-WAIT → outputs at reset values immediately, late response ignored.
